// File: rtl/dpa_regs_pkg.sv
// Shared constants and state types for the dot-product accelerator register block.
package dpa_regs_pkg;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Status word bit positions
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   // Register word indices
   localparam int REG_CTRL     = 0;
   localparam int REG_VEC_A    = 1;
   localparam int REG_VEC_B    = 2;
   localparam int REG_LEN      = 3;
   localparam int REG_OUT_ADDR = 4;
   localparam int REG_STATUS   = 5;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_HAVE_A = 2'd1,
      W_HAVE_D = 2'd2,
      W_RESP   = 2'd3
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage

// File: rtl/dpa_status_reg.sv
// Status word: busy/done/error flags, cleared by W1C writes and set by datapath events.
// A hardware set always beats a software clear of the same bit in the same cycle.
module dpa_status_reg
   import dpa_regs_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              w1c_en,
   input  logic [2:0]        w1c_bits,
   input  logic              set_busy,
   input  logic              set_done,
   input  logic              set_error,
   output logic [DATA_W-1:0] status
);

   logic busy_q, done_q, err_q;
   logic busy_d, done_d, err_d;

   // Next flag values: apply W1C first, then hardware events (error > done > busy)
   always_comb begin
      busy_d = busy_q;
      done_d = done_q;
      err_d  = err_q;
      if (w1c_en) begin
         busy_d = busy_q & ~w1c_bits[STAT_BUSY];
         done_d = done_q & ~w1c_bits[STAT_DONE];
         err_d  = err_q  & ~w1c_bits[STAT_ERR];
      end
      if (set_error) begin
         err_d  = 1'b1;
         busy_d = 1'b0;
      end else if (set_done) begin
         done_d = 1'b1;
         busy_d = 1'b0;
      end else if (set_busy) begin
         busy_d = 1'b1;
      end
   end

   // Flag registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   // Pack flags into the status word; reserved bits read as zero
   always_comb begin
      status            = '0;
      status[STAT_BUSY] = busy_q;
      status[STAT_DONE] = done_q;
      status[STAT_ERR]  = err_q;
   end

endmodule

// File: rtl/axil_reg_block_param.sv
// AXI4-Lite control/status register file for the dot-product accelerator.
// Handshake rule for every channel: a transfer happens on a rising ACLK edge where
// VALID and READY are both high; VALID, once raised, holds its payload until that edge.
// All READY outputs are registered, so they are low in the first cycle after reset.
module axil_reg_block_param
   import dpa_regs_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 8,
   parameter int CTRL_IDX   = REG_CTRL,
   parameter int STATUS_IDX = REG_STATUS
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   input  logic                     AWVALID,
   input  logic [ADDR_W-1:0]        AWADDR,
   output logic                     AWREADY,
   input  logic                     WVALID,
   input  logic [DATA_W-1:0]        WDATA,
   input  logic [DATA_W/8-1:0]      WSTRB,
   output logic                     WREADY,
   output logic                     BVALID,
   output logic [1:0]               BRESP,
   input  logic                     BREADY,
   input  logic                     ARVALID,
   input  logic [ADDR_W-1:0]        ARADDR,
   output logic                     ARREADY,
   output logic                     RVALID,
   output logic [DATA_W-1:0]        RDATA,
   output logic [1:0]               RRESP,
   input  logic                     RREADY,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic                     start_pulse,
   input  logic                     set_busy,
   input  logic                     set_done,
   input  logic                     set_error
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // Word-aligned and inside the register window
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a[1:0] == 2'b00) && (a[ADDR_W-1:2] < (ADDR_W-2)'(NUM_REGS));
   endfunction

   wr_state_t           wr_state, wr_next;
   rd_state_t           rd_state, rd_next;
   logic                awready_q, wready_q, arready_q;
   logic [ADDR_W-1:0]   aw_hold;
   logic [DATA_W-1:0]   w_hold;
   logic [STRB_W-1:0]   s_hold;
   logic [1:0]          bresp_q, rresp_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                start_q;

   logic                aw_hs, w_hs, ar_hs;
   logic                commit;
   logic [ADDR_W-1:0]   c_addr;
   logic [DATA_W-1:0]   c_data;
   logic [STRB_W-1:0]   c_strb;
   logic [IDX_W-1:0]    c_idx, r_idx;
   logic                c_start, c_okay, wr_en;

   logic [DATA_W-1:0]   regs     [NUM_REGS];
   logic [DATA_W-1:0]   reg_view [NUM_REGS];
   logic [DATA_W-1:0]   status;

   assign aw_hs = AWVALID && awready_q;
   assign w_hs  = WVALID  && wready_q;
   assign ar_hs = ARVALID && arready_q;

   // Write FSM next state and selection of the address/data that commit this cycle
   always_comb begin
      wr_next = wr_state;
      commit  = 1'b0;
      c_addr  = aw_hold;
      c_data  = w_hold;
      c_strb  = s_hold;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit  = 1'b1;
               c_addr  = AWADDR;
               c_data  = WDATA;
               c_strb  = WSTRB;
               wr_next = W_RESP;
            end else if (aw_hs) begin
               wr_next = W_HAVE_A;
            end else if (w_hs) begin
               wr_next = W_HAVE_D;
            end
         end
         W_HAVE_A: begin
            if (w_hs) begin
               commit  = 1'b1;
               c_data  = WDATA;
               c_strb  = WSTRB;
               wr_next = W_RESP;
            end
         end
         W_HAVE_D: begin
            if (aw_hs) begin
               commit  = 1'b1;
               c_addr  = AWADDR;
               wr_next = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // Commit decode: address check plus the start-while-busy rejection
   always_comb begin
      c_idx   = c_addr[IDX_W+1:2];
      c_start = c_data[0] && c_strb[0] && (c_idx == IDX_W'(CTRL_IDX));
      c_okay  = addr_ok(c_addr) && !(c_start && status[STAT_BUSY]);
      wr_en   = commit && c_okay;
   end

   // Write channel state, holding registers, response and start pulse
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_state  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         aw_hold   <= '0;
         w_hold    <= '0;
         s_hold    <= '0;
         bresp_q   <= RESP_OKAY;
         start_q   <= 1'b0;
      end else begin
         wr_state  <= wr_next;
         awready_q <= (wr_next == W_IDLE) || (wr_next == W_HAVE_D);
         wready_q  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_A);
         if (aw_hs) aw_hold <= AWADDR;
         if (w_hs) begin
            w_hold <= WDATA;
            s_hold <= WSTRB;
         end
         if (commit) bresp_q <= c_okay ? RESP_OKAY : RESP_SLVERR;
         start_q <= wr_en && c_start;
      end
   end

   // Plain registers with byte-lane writes; CTRL bit0 self-clears when the datapath finishes
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (wr_en && (c_idx != IDX_W'(STATUS_IDX))) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (c_strb[b]) regs[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
            end
         end
         if (set_done || set_error) regs[CTRL_IDX][0] <= 1'b0;
      end
   end

   dpa_status_reg #(
      .DATA_W (DATA_W)
   ) u_status (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .w1c_en    (wr_en && (c_idx == IDX_W'(STATUS_IDX))),
      .w1c_bits  (c_data[2:0] & {3{c_strb[0]}}),
      .set_busy  (set_busy),
      .set_done  (set_done),
      .set_error (set_error),
      .status    (status)
   );

   // Register view as seen by reads and regs_o (status word comes from its own block)
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) reg_view[i] = regs[i];
      reg_view[STATUS_IDX] = status;
   end

   // Flatten the register view
   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = reg_view[i];
   end

   // Read FSM next state
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs)  rd_next = R_DATA;
         R_DATA:  if (RREADY) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   assign r_idx = ARADDR[IDX_W+1:2];

   // Read channel state and registered read data/response
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         rd_state  <= rd_next;
         arready_q <= (rd_next == R_IDLE);
         if (ar_hs) begin
            if (addr_ok(ARADDR)) begin
               rdata_q <= reg_view[r_idx];
               rresp_q <= RESP_OKAY;
            end else begin
               rdata_q <= '0;
               rresp_q <= RESP_SLVERR;
            end
         end
      end
   end

   assign AWREADY     = awready_q;
   assign WREADY      = wready_q;
   assign BVALID      = (wr_state == W_RESP);
   assign BRESP       = bresp_q;
   assign ARREADY     = arready_q;
   assign RVALID      = (rd_state == R_DATA);
   assign RDATA       = rdata_q;
   assign RRESP       = rresp_q;
   assign start_pulse = start_q;

endmodule

// File: doc/axil_reg_block_param.md
Name: axil_reg_block_param

Overview:
Parametrised AXI4-Lite register slave for the dot-product accelerator. It is the next-generation control/status register file, replacing the fixed six-register block. It adds:
- independent AW/W acceptance and WSTRB byte lanes
- a true read channel with SLVERR decode
- a W1C status register and a start pulse

It sits between the testbench/host AXI-Lite master and the accelerator datapath FSM.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, register/data width (multiple of 8)
NUM_REGS, 8, number of word registers (>= 6, power of 2 not required)
CTRL_IDX, 0, index of control register (bit0 = start)
STATUS_IDX, 5, index of status register (bit0 busy, bit1 done, bit2 error)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWADDR  in  ADDR_W  write address
AWREADY  out  1  write address accepted
WVALID  in  1  write data valid
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte-lane enables
WREADY  out  1  write data accepted
BVALID  out  1  write response valid
BRESP  out  2  00 OKAY, 10 SLVERR
BREADY  in  1  master accepts response
ARVALID  in  1  read address valid
ARADDR  in  ADDR_W  read address
ARREADY  out  1  read address accepted
RVALID  out  1  read data valid
RDATA  out  DATA_W  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RREADY  in  1  master accepts read data
regs_o  out  NUM_REGS*DATA_W  flattened register contents, reg i at [i*DATA_W +: DATA_W]
start_pulse  out  1  one-cycle start to datapath
set_busy  in  1  datapath busy event
set_done  in  1  datapath done event
set_error  in  1  datapath error event

Behaviour:
- Clocking and reset: one clock, ACLK. Reset is asynchronous and active-low on ARESETn.
- Reset values: all registers 0; BVALID, RVALID, start_pulse 0; BRESP, RRESP, RDATA 0. AWREADY, WREADY, ARREADY are registered: 0 during reset, 1 from the first edge after release.
- Decode:
  - Index = addr >> 2.
  - OKAY iff addr[1:0]==0 and index < NUM_REGS; otherwise SLVERR.
  - SLVERR writes modify nothing.
- Write FSM: states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - AW and W are captured independently into holding registers.
  - AWREADY deasserts once an address is held; WREADY deasserts once data is held.
  - Same-cycle AW+W in W_IDLE commits directly.
  - Commit occurs on the edge where both are available; BVALID rises the next cycle (state W_RESP). BRESP is stable while BVALID is high.
  - On BVALID && BREADY: return to W_IDLE and re-assert both readies the following cycle.
  - Throughput: at most one write per 2 cycles.
- Byte strobes: only lanes with WSTRB=1 update. WSTRB=0 is OKAY with no change.
- Control register (CTRL_IDX):
  - A write with bit0=1 while status busy=0 sets bit0 and pulses start_pulse for exactly 1 cycle, on the cycle after commit.
  - A write with bit0=1 while busy=1 returns SLVERR; the register is unchanged and there is no pulse.
  - Bit0 is cleared by hardware on set_done or set_error.
- Status register (STATUS_IDX), W1C:
  - A written 1 clears that bit; a written 0 has no effect.
  - set_busy sets busy.
  - set_done sets done and clears busy.
  - set_error sets error and clears busy.
  - Priority: error > done > busy.
  - A hardware set in the same cycle as a W1C of the same bit: set wins.
  - Reserved bits [DATA_W-1:3] read 0.
- Read FSM: states R_IDLE, R_DATA.
  - ARREADY=1 only in R_IDLE.
  - On AR handshake, RDATA/RRESP are registered and RVALID is asserted next cycle (latency 1). RDATA/RRESP are held stable until RREADY.
  - Invalid address: RDATA=0, RRESP=10.
  - Returns to R_IDLE on RVALID && RREADY; ARREADY is high the following cycle.
- Read/write concurrency: the channels are independent. A read and a commit to the same register in the same cycle returns the pre-write value.
- Reset mid-transaction: held address/data are discarded. BVALID/RVALID drop immediately (asynchronous). No partial write persists.
- regs_o reflects the registered values only; it is never a combinational bypass.

Decomposition:
- Package dpa_regs_pkg holds:
  - RESP_OKAY/RESP_SLVERR constants
  - STAT_BUSY/STAT_DONE/STAT_ERR bit indices
  - register index constants (CTRL, VEC_A, VEC_B, LEN, OUT_ADDR, STATUS)
  - wr_state_t and rd_state_t enums
- One natural sub-module: dpa_status_reg, containing the W1C/hardware-set priority logic for the status word.

Test Plan:
- AWVALID at cycle 0, WVALID at cycle 3 (addr 0x04, data 0xA5A5_0001, strb 0xF) -> AWREADY drops at cycle 1; commit on the W edge; BVALID the next cycle with BRESP=00; a read of 0x04 returns 0xA5A5_0001.
- Write 0xFFFF_FFFF with WSTRB=0x5 to 0x08 after reset -> reads 0x00FF_00FF.
- Write and read to 0x40 and to 0x06 -> BRESP=10, RRESP=10, RDATA=0; no register changes.
- Write 0x1 to 0x00 -> start_pulse high exactly 1 cycle; then set_busy; a second write of 0x1 -> SLVERR, no pulse; then set_done -> status reads 0x2, CTRL bit0 reads 0.
- Status 0x6; W1C write 0x2 in the same cycle as set_done -> status stays 0x6; a later W1C of 0x6 -> status reads 0x0.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RDATA stable, AWREADY/ARREADY stay 0; assert ARESETn low mid-wait -> all valids 0 asynchronously and registers 0.
